// File: rtl/gate_2_exerciser_if.sv
// Gate-under-test bundle: stimulus A/B out, response Y in,
// plus run control and result reporting.
interface gate_2_exerciser_if;
  logic       START;
  logic       Y;
  logic       A;
  logic       B;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] FAIL_MASK;
  logic [7:0] ERR_CNT;

  modport master (
    input  START, Y,
    output A, B, BUSY, DONE, PASS,
    output FAIL_MASK, ERR_CNT
  );

  modport slave (
    output START, Y,
    input  A, B, BUSY, DONE, PASS,
    input  FAIL_MASK, ERR_CNT
  );
endinterface

// File: rtl/gate_2_exerciser.sv
// Truth-table walker for a 2-input gate: drives AB=00..11,
// waits SETTLE cycles per vector, checks Y against TRUTH.
module gate_2_exerciser #(
  parameter logic [3:0] TRUTH  = 4'b1110,
  parameter int         SETTLE = 2
) (
  input logic CLK,
  input logic RST_N,
  gate_2_exerciser_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPORT
  } state_e;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  logic       pass_q, pass_d;
  logic [7:0] err_q, err_d;
  logic       miss;

  assign miss = bus.Y != TRUTH[v_q];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      v_q     <= 2'd0;
      cnt_q   <= 4'd0;
      mask_q  <= 4'd0;
      pass_q  <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, REPORT: begin
        state_d = IDLE;
        if (bus.START) begin
          state_d = HOLD;
          v_d     = 2'd0;
          cnt_d   = RELOAD;
          mask_d  = 4'd0;
        end
      end
      HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (miss) begin
            mask_d[v_q] = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
          if (v_q != 2'd3) begin
            v_d   = v_q + 2'd1;
            cnt_d = RELOAD;
          end else begin
            state_d = REPORT;
            pass_d  = mask_d == 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.A         = v_q[1];
  assign bus.B         = v_q[0];
  assign bus.BUSY      = state_q == HOLD;
  assign bus.DONE      = state_q == REPORT;
  assign bus.PASS      = pass_q;
  assign bus.FAIL_MASK = mask_q;
  assign bus.ERR_CNT   = err_q;

endmodule

// File: tb/tb_gate_2_exerciser.sv
// Bench: three exercisers (SETTLE 1, 2, 15) against an emulated
// gate, checked every cycle by an edge-count timeline model.
module tb_gate_2_exerciser;

  localparam logic [3:0] TRUTH = 4'b1110;
  localparam logic [3:0] G_OR  = 4'b1110;
  localparam logic [3:0] G_AND = 4'b1000;
  localparam logic [3:0] G_0   = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start = '0;
  logic [2:0] y = '0;
  logic [2:0] noise = '0;
  logic [3:0] gtbl [3];
  int         S [3] = '{1, 2, 15};
  bit         chk_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;

  logic [2:0] oa, ob, obusy, odone, opass;
  logic [3:0] omask [3];
  logic [7:0] oerr [3];

  logic [1:0] m_v [3];
  logic       m_run [3];
  logic       m_done [3];
  logic       m_pass [3];
  logic [3:0] m_mask [3];
  int         m_k [3];
  int         m_err [3];

  gate_2_exerciser_if if0 ();
  gate_2_exerciser_if if1 ();
  gate_2_exerciser_if if2 ();

  gate_2_exerciser #(.TRUTH(TRUTH), .SETTLE(1))
    d0 (.CLK(clk), .RST_N(rst_n), .bus(if0.master));
  gate_2_exerciser #(.TRUTH(TRUTH), .SETTLE(2))
    d1 (.CLK(clk), .RST_N(rst_n), .bus(if1.master));
  gate_2_exerciser #(.TRUTH(TRUTH), .SETTLE(15))
    d2 (.CLK(clk), .RST_N(rst_n), .bus(if2.master));

  assign if0.START = start[0];
  assign if1.START = start[1];
  assign if2.START = start[2];
  assign if0.Y = y[0];
  assign if1.Y = y[1];
  assign if2.Y = y[2];
  assign oa    = {if2.A, if1.A, if0.A};
  assign ob    = {if2.B, if1.B, if0.B};
  assign obusy = {if2.BUSY, if1.BUSY, if0.BUSY};
  assign odone = {if2.DONE, if1.DONE, if0.DONE};
  assign opass = {if2.PASS, if1.PASS, if0.PASS};
  assign omask[0] = if0.FAIL_MASK;
  assign omask[1] = if1.FAIL_MASK;
  assign omask[2] = if2.FAIL_MASK;
  assign oerr[0]  = if0.ERR_CNT;
  assign oerr[1]  = if1.ERR_CNT;
  assign oerr[2]  = if2.ERR_CNT;

  always #5 clk = ~clk;

  // Model: a run is a timeline of edges k=1..4S after the START edge;
  // vector n is sampled at k=(n+1)S.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0;
        m_v[i] = 0; m_mask[i] = 0; m_k[i] = 0; m_err[i] = 0;
      end else begin
        m_done[i] = 0;
        if (m_run[i]) begin
          m_k[i]++;
          if (m_k[i] % S[i] == 0) begin
            int n;
            n = m_k[i] / S[i] - 1;
            if (y[i] != TRUTH[n]) begin
              m_mask[i][n] = 1'b1;
              if (m_err[i] < 255) m_err[i]++;
            end
            if (n == 3) begin
              m_run[i] = 0;
              m_done[i] = 1;
              m_pass[i] = m_mask[i] == 4'd0;
            end else begin
              m_v[i] = 2'(n + 1);
            end
          end
        end else if (start[i]) begin
          m_run[i] = 1; m_k[i] = 0; m_v[i] = 0; m_mask[i] = 0;
        end
      end
    end
  end

  // Gate emulation; optional wrong Y on every non-sampling cycle.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      logic sn, good;
      sn = m_run[i] && ((m_k[i] + 1) % S[i] == 0);
      good = gtbl[i][{oa[i], ob[i]}];
      y[i] = good ^ (noise[i] & ~sn & 1'($urandom));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [16:0] e, a;
        e = {m_v[i], m_run[i], m_done[i], m_pass[i],
             m_mask[i], 8'(m_err[i])};
        a = {oa[i], ob[i], obusy[i], odone[i], opass[i],
             omask[i], oerr[i]};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle%0d dut%0d got %h want %h",
                   cyc, i, a, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run(input int i, input logic [3:0] g,
                     output int lat);
    @(negedge clk);
    gtbl[i] = g;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    lat = 0;
    while (!odone[i] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, last, np, bad;
    for (int i = 0; i < 3; i++) gtbl[i] = G_OR;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy", int'(obusy), 0);
    chk("rst_err", int'(oerr[1]), 0);

    run(1, G_OR, lat);
    chk("or_lat", lat, 8);
    chk("or_pass", int'(opass[1]), 1);
    chk("or_mask", int'(omask[1]), 0);
    chk("or_ab", int'({oa[1], ob[1]}), 3);

    run(1, G_AND, lat);
    chk("and_mask", int'(omask[1]), 4'b0110);
    chk("and_pass", int'(opass[1]), 0);
    chk("and_err1", int'(oerr[1]), 2);
    run(1, G_AND, lat);
    chk("and_err2", int'(oerr[1]), 4);

    @(negedge clk);
    gtbl[1] = G_OR;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ab", int'({oa[1], ob[1]}), 0);
    chk("rst_busy1", int'(obusy[1]), 0);
    np = 0;
    repeat (10) begin
      @(negedge clk);
      if (odone[1]) np++;
    end
    chk("rst_nodone", np, 0);
    run(1, G_OR, lat);
    chk("post_rst_pass", int'(opass[1]), 1);

    for (int r = 1; r <= 85; r++) run(1, G_0, lat);
    chk("sat_85", int'(oerr[1]), 255);
    chk("zero_mask", int'(omask[1]), 4'b1110);
    run(1, G_0, lat);
    chk("sat_86", int'(oerr[1]), 255);
    chk("sat_pass", int'(opass[1]), 0);

    noise[2] = 1'b1;
    run(2, G_OR, lat);
    chk("s15_lat", lat, 60);
    chk("s15_pass", int'(opass[2]), 1);
    chk("s15_err", int'(oerr[2]), 0);

    @(negedge clk);
    gtbl[0] = G_OR;
    start[0] = 1'b1;
    last = -1; np = 0; bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (odone[0]) begin
        if (last >= 0 && c - last != 5) bad++;
        last = c;
        np++;
      end
    end
    start[0] = 1'b0;
    chk("b2b_pulses", np, 8);
    chk("b2b_period", bad, 0);
    chk("b2b_err", int'(oerr[0]), 0);
    repeat (8) @(negedge clk);

    noise = 3'b111;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!m_run[i] && $urandom_range(0, 3) == 0)
          gtbl[i] = 4'($urandom);
        start[i] = $urandom_range(0, 3) == 0;
      end
    end
    start = '0;
    repeat (70) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
